// File: rtl/p_ssync_nbit_edge.sv
// p_ssync_nbit_edge
// Multi-bit level synchroniser with registered rise/fall pulses per channel
// and an any-change flag. Each of the WIDTH channels is independent and passes
// through a STAGES-deep flop chain: STAGES-1 chain flops plus the output
// register q.
// Optional build macro: SSYNC_GLITCH_FILTER_EN. When it is defined, q only
// follows the synchronised input after that input has differed from q for
// FILT_CNT consecutive clocks. A shorter excursion is dropped without pulses.
module p_ssync_nbit_edge #(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter int               FILT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg_any
);

  // Catch illegal depth or filter length when the design is elaborated
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("p_ssync_nbit_edge: STAGES=%0d outside legal range 2..8", STAGES);
  end
  if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_filt
    $error("p_ssync_nbit_edge: FILT_CNT=%0d outside legal range 1..255", FILT_CNT);
  end

  // Entry 0 is the capture flop. The last entry is the synchronised level sy.
  logic [STAGES-2:0][WIDTH-1:0] syncChain_q;
  logic [WIDTH-1:0]             sy;

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chgAny_q, chgAny_d;

  assign sy = syncChain_q[STAGES-2];

  // Shift each channel through its synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      syncChain_q <= {(STAGES-1){RST_VAL}};
    end else begin
      syncChain_q[0] <= d;
      for (int k = 1; k < STAGES - 1; k++) begin
        syncChain_q[k] <= syncChain_q[k-1];
      end
    end
  end

`ifdef SSYNC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_CNT + 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles in which sy disagrees with q.
  // The change is accepted only once the disagreement has lasted FILT_CNT cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sy[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILT_CNT - 1)) begin
        level_d[i] = sy[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Hold the per-channel stability counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the filter, q is simply the next flop after sy
  always_comb begin
    level_d = sy;
  end
`endif

  // Detect edges against the next q value so that pulses line up with the new q
  always_comb begin
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    chgAny_d = |(rise_d | fall_d);
  end

  // Register the output level, the edge pulses and the any-change flag together
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      chgAny_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      chgAny_q <= chgAny_d;
    end
  end

  assign q       = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign chg_any = chgAny_q;

endmodule
